// File: rtl/ysyx_24100029_ifu_prefetch.sv
// Prefetching IFU: AXI4 read master with several single-beat reads in flight feeding an in-order queue.
// Optional IFU_PERF_CNT_EN adds perf_fetch_cnt / perf_drop_cnt outputs.
//
// state   | meaning
// --------+-------------------------------------------------------------
// S_FETCH | normal operation, new ARs issued while credit allows
// S_FLUSH | after redirect, waiting for stale beats / pending AR to clear
// S_HALT  | faulting entry queued, no new ARs until a redirect
module ysyx_24100029_ifu_prefetch #(
   parameter logic [31:0] RESET_PC = 32'h3000_0000,
   parameter int          FQ_DEPTH = 4,
   parameter int          MAX_OUT  = 2,
   parameter logic [3:0]  AXI_ID   = 4'h0
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        redirect_valid,
   input  logic [31:0] redirect_pc,
   output logic        valid,
   input  logic        ready,
   output logic [31:0] pc,
   output logic [31:0] inst,
   output logic        fault,
   output logic        arvalid,
   input  logic        arready,
   output logic [31:0] araddr,
   output logic [3:0]  arid,
   output logic [7:0]  arlen,
   output logic [2:0]  arsize,
   output logic [1:0]  arburst,
   input  logic        rvalid,
   output logic        rready,
   input  logic [31:0] rdata,
   input  logic [1:0]  rresp,
   input  logic        rlast,
`ifdef IFU_PERF_CNT_EN
   output logic [31:0] perf_fetch_cnt,
   output logic [31:0] perf_drop_cnt,
`endif
   input  logic [3:0]  rid
);

   localparam int PW = $clog2(FQ_DEPTH);
   localparam int TW = (MAX_OUT > 1) ? $clog2(MAX_OUT) : 1;

   typedef enum logic [1:0] {S_FETCH, S_FLUSH, S_HALT} state_t;

   state_t        state, state_next;
   logic [31:0]   fpc;
   logic [31:0]   araddr_q;
   logic          arvalid_q;
   logic [PW-1:0] head, tail;
   logic [7:0]    count, outstanding, drop_cnt;
   logic [7:0]    out_after, cnt_after, drop_next;
   logic [TW-1:0] tag_wr, tag_rd;

   logic [31:0]   q_pc   [FQ_DEPTH];
   logic [31:0]   q_inst [FQ_DEPTH];
   logic          q_fault[FQ_DEPTH];
   logic [31:0]   tag_mem[MAX_OUT];

   logic ar_accept, ar_hold, push, pop, push_fault, launch, arvalid_next;
   logic unused_ok;

   function automatic logic [TW-1:0] tag_inc(input logic [TW-1:0] p);
      return (p == TW'(MAX_OUT - 1)) ? '0 : p + TW'(1);
   endfunction

   assign ar_accept  = arvalid_q & arready;
   assign ar_hold    = arvalid_q & ~arready;
   assign push       = rvalid && (drop_cnt == 8'd0) && !redirect_valid;
   assign pop        = valid && ready && !redirect_valid;
   assign push_fault = (rresp != 2'b00);

   assign out_after = outstanding + {7'd0, ar_accept} - {7'd0, rvalid};
   assign cnt_after = redirect_valid ? 8'd0 : (count + {7'd0, push} - {7'd0, pop});

   // Credit is judged on post-cycle occupancy so issue can continue back-to-back.
   assign launch = !redirect_valid && (state_next == S_FETCH) && !ar_hold &&
                   (out_after < 8'(MAX_OUT)) && ((out_after + cnt_after) < 8'(FQ_DEPTH));
   assign arvalid_next = ar_hold | launch;

   always_comb begin
      state_next = state;
      drop_next  = drop_cnt;
      if (redirect_valid) begin
         // every response owed for a request issued before the redirect is stale
         drop_next  = outstanding - {7'd0, rvalid} + {7'd0, arvalid_q};
         state_next = (drop_next != 8'd0 || ar_hold) ? S_FLUSH : S_FETCH;
      end else begin
         if (rvalid && drop_cnt != 8'd0) drop_next = drop_cnt - 8'd1;
         case (state)
            S_FETCH: if (push && push_fault) state_next = S_HALT;
            S_FLUSH: if (drop_cnt == 8'd0 && !arvalid_q) state_next = S_FETCH;
            default: state_next = state;
         endcase
      end
   end

   always_ff @(posedge clock) begin
      if (!reset) begin
         state       <= S_FETCH;
         fpc         <= RESET_PC;
         araddr_q    <= '0;
         arvalid_q   <= 1'b0;
         head        <= '0;
         tail        <= '0;
         count       <= '0;
         outstanding <= '0;
         drop_cnt    <= '0;
         tag_wr      <= '0;
         tag_rd      <= '0;
      end else begin
         state       <= state_next;
         arvalid_q   <= arvalid_next;
         outstanding <= out_after;
         drop_cnt    <= drop_next;
         count       <= cnt_after;
         if (redirect_valid)
            fpc <= {redirect_pc[31:2], 2'b00};
         else if (launch)
            fpc <= fpc + 32'd4;
         if (launch) araddr_q <= fpc;
         if (redirect_valid) begin
            head <= '0;
            tail <= '0;
         end else begin
            if (push) begin
               q_pc[tail]    <= tag_mem[tag_rd];
               q_inst[tail]  <= rdata;
               q_fault[tail] <= push_fault;
               tail          <= tail + PW'(1);
            end
            if (pop) head <= head + PW'(1);
         end
         // tag FIFO tracks every issued address, dropped or not, to stay aligned with R order
         if (ar_accept) begin
            tag_mem[tag_wr] <= araddr_q;
            tag_wr          <= tag_inc(tag_wr);
         end
         if (rvalid) tag_rd <= tag_inc(tag_rd);
      end
   end

`ifdef IFU_PERF_CNT_EN
   always_ff @(posedge clock) begin
      if (!reset) begin
         perf_fetch_cnt <= '0;
         perf_drop_cnt  <= '0;
      end else begin
         if (ar_accept) perf_fetch_cnt <= perf_fetch_cnt + 32'd1;
         if (rvalid && (redirect_valid || drop_cnt != 8'd0)) perf_drop_cnt <= perf_drop_cnt + 32'd1;
      end
   end
`endif

   assign valid   = (count != 8'd0);
   assign pc      = valid ? q_pc[head]   : '0;
   assign inst    = valid ? q_inst[head] : '0;
   assign fault   = valid ? q_fault[head] : 1'b0;
   assign arvalid = arvalid_q;
   assign araddr  = araddr_q;
   assign arid    = AXI_ID;
   assign arlen   = 8'd0;
   assign arsize  = 3'b010;
   assign arburst = 2'b01;
   assign rready  = 1'b1;

   assign unused_ok = ^{redirect_pc[1:0], rlast, rid};

endmodule
